// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: state encoding and default timing shared with flutter_free
package pulse_stretcher_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ON = 2'b01, GAP = 2'b10} state_e;
  localparam int T_ON_DEF  = 2000000;
  localparam int T_OFF_DEF = 2000000;
endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt: saturating up/down counter; ovf flags an increment lost at max
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         ovf
);
  logic [W-1:0] count_q, count_d;
  assign at_max = &count_q;
  assign ovf    = inc && !dec && at_max;
  assign count  = count_q;
  always_comb
    count_d = (inc && !dec && !at_max)        ? count_q + 1'b1 :
              (dec && !inc && count_q != '0)  ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches event pulses to T_ON high / >=T_OFF low, queuing busy-time events.
// Define PULSE_STRETCHER_RETRIGGER_EN to make pulses during ON extend the high phase instead.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int T_ON   = T_ON_DEF,
  parameter int T_OFF  = T_OFF_DEF,
  parameter int CNT_W  = 21,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, busy_q, inc, dec, on_last, gap_last, pend_nz, retrig, at_max;
  assign on_last  = cnt_q == CNT_W'(T_ON - 1);
  assign gap_last = cnt_q == CNT_W'(T_OFF - 1);
  assign pend_nz  = pend_cnt != '0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign retrig = state_q == ON && pulse_in;
`else
  assign retrig = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && pulse_in) state_d = ON;
    if (state_q == ON && on_last && !retrig) state_d = GAP;
    if (state_q == GAP && gap_last) state_d = (pend_nz || pulse_in) ? ON : IDLE;
    // a pulse on the final gap cycle with an empty queue starts the next phase directly
    inc   = pulse_in && !retrig && (state_q == ON || (state_q == GAP && !(gap_last && !pend_nz)));
    dec   = state_q == GAP && gap_last && pend_nz;
    cnt_d = (state_d != state_q || retrig || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= state_d == ON;
      busy_q  <= state_d != IDLE;
    end
  sat_updown_cnt #(.W(PEND_W)) u_pend (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .dec    (dec),
    .count  (pend_cnt),
    .at_max (at_max),
    .ovf    (overflow)
  );
  assign out  = out_q;
  assign busy = busy_q;
endmodule
